dice_cgra_dispatch_ctrl: RTL and testbench

DICE_CGRA_DISPATCH_CTRL -- requirements
Module: dice_cgra_dispatch_ctrl

---
 rtl/dice_cgra_dispatch_ctrl.sv | 103 ++++++++++
 tb/tb_dice_cgra_dispatch_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/dice_cgra_dispatch_ctrl.sv
// dice_cgra_dispatch_ctrl: thread-block dispatcher (IDLE/CLEAR/ISSUE/DRAIN/DONE) issuing linear and 3-D thread IDs to a CGRA; ports: start/start_ready handshake with tid_count/ntid_x/ntid_y, stall/abort/cgra_done controls, cgra_clr, disp_valid/disp_tid/tid_x/y/z, busy, blk_done
module dice_cgra_dispatch_ctrl #(
  parameter int NUM_TID     = 512,
  parameter int TID_WIDTH   = $clog2(NUM_TID),
  parameter int DRAIN_GUARD = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 start_ready,
  input  logic [TID_WIDTH:0]   tid_count,
  input  logic [TID_WIDTH-1:0] ntid_x,
  input  logic [TID_WIDTH-1:0] ntid_y,
  input  logic                 stall,
  input  logic                 abort,
  input  logic                 cgra_done,
  output logic                 cgra_clr,
  output logic                 disp_valid,
  output logic [TID_WIDTH-1:0] disp_tid,
  output logic [TID_WIDTH-1:0] tid_x,
  output logic [TID_WIDTH-1:0] tid_y,
  output logic [TID_WIDTH-1:0] tid_z,
  output logic                 busy,
  output logic                 blk_done
);
  typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, DRAIN, DONE} state_e;
  localparam int GW = $clog2(DRAIN_GUARD + 2);
  localparam logic [TID_WIDTH:0] ONE_C = 1;
  localparam logic [TID_WIDTH:0] MAX_C = (TID_WIDTH+1)'(NUM_TID);
  localparam logic [TID_WIDTH-1:0] ONE_T = 1;
  state_e state_q;
  logic [TID_WIDTH:0] tcnt_q;
  logic [TID_WIDTH-1:0] nx_q, ny_q, tid_q, x_q, y_q, z_q;
  logic [TID_WIDTH-1:0] nx_m1, ny_m1, x_d, y_d, z_d;
  logic [GW-1:0] g_q;
  logic kill, last, x_wrap, y_wrap, guard_ok;
  assign kill = abort && (state_q inside {CLEAR, ISSUE, DRAIN});
  assign last = ({1'b0, tid_q} + ONE_C) == tcnt_q;
  // a zero dimension behaves as size 1, so it wraps on every step
  assign nx_m1 = (nx_q == '0) ? '0 : nx_q - ONE_T;
  assign ny_m1 = (ny_q == '0) ? '0 : ny_q - ONE_T;
  assign x_wrap = x_q == nx_m1;
  assign y_wrap = y_q == ny_m1;
  assign x_d = x_wrap ? '0 : x_q + ONE_T;
  assign y_d = !x_wrap ? y_q : (y_wrap ? '0 : y_q + ONE_T);
  assign z_d = (x_wrap && y_wrap) ? z_q + ONE_T : z_q;
  // guard counts from DRAIN entry, so an early cgra_done cannot cut it short
  assign guard_ok = int'(g_q) + 1 >= DRAIN_GUARD;
  assign start_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign cgra_clr = state_q == CLEAR || kill;
  assign disp_valid = state_q == ISSUE && !stall && !abort;
  assign blk_done = state_q == DONE;
  assign disp_tid = tid_q;
  assign tid_x = x_q;
  assign tid_y = y_q;
  assign tid_z = z_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tcnt_q <= '0;
      nx_q <= '0;
      ny_q <= '0;
      tid_q <= '0;
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
      g_q <= '0;
    end else if (kill) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q <= CLEAR;
          tcnt_q <= (tid_count > MAX_C) ? MAX_C : tid_count;
          nx_q <= ntid_x;
          ny_q <= ntid_y;
          tid_q <= '0;
          x_q <= '0;
          y_q <= '0;
          z_q <= '0;
        end
        CLEAR: state_q <= (tcnt_q == '0) ? DONE : ISSUE;
        ISSUE: if (!stall) begin
          tid_q <= tid_q + ONE_T;
          x_q <= x_d;
          y_q <= y_d;
          z_q <= z_d;
          if (last) begin
            state_q <= DRAIN;
            g_q <= '0;
          end
        end
        DRAIN: begin
          if (guard_ok && cgra_done) state_q <= DONE;
          else if (int'(g_q) < DRAIN_GUARD) g_q <= g_q + GW'(1);
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dice_cgra_dispatch_ctrl.sv
// tb_dice_cgra_dispatch_ctrl: table-driven blocks with an ID scoreboard plus abort and reset sequences
module tb_dice_cgra_dispatch_ctrl;
  localparam int NT = 512;
  localparam int TW = 9;
  localparam int G = 2;
  logic clk = 0, rst_n = 0, start = 0, stall = 0, abort = 0, cgra_done = 0;
  logic [TW:0] tid_count = '0;
  logic [TW-1:0] ntid_x = '0, ntid_y = '0;
  logic start_ready, cgra_clr, disp_valid, busy, blk_done;
  logic [TW-1:0] disp_tid, tid_x, tid_y, tid_z;
  int total = 0, bad = 0;
  logic [4*TW-1:0] sbq[$];
  typedef struct {
    int tc; int nx; int ny; logic [31:0] mask; int low; bit hold; bit abz; int done;
  } blk_t;
  blk_t tbl[8];

  dice_cgra_dispatch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_ready(start_ready),
    .tid_count(tid_count), .ntid_x(ntid_x), .ntid_y(ntid_y), .stall(stall),
    .abort(abort), .cgra_done(cgra_done), .cgra_clr(cgra_clr),
    .disp_valid(disp_valid), .disp_tid(disp_tid), .tid_x(tid_x), .tid_y(tid_y),
    .tid_z(tid_z), .busy(busy), .blk_done(blk_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_model(input int tc, input int nx, input int ny);
    int nxe, nye;
    nxe = (nx == 0) ? 1 : nx;
    nye = (ny == 0) ? 1 : ny;
    for (int i = 0; i < tc; i++)
      sbq.push_back({TW'(i), TW'(i % nxe), TW'((i / nxe) % nye), TW'(i / (nxe * nye))});
  endtask

  task automatic run_block(input blk_t b);
    int tce, ie, k;
    logic [4*TW-1:0] e;
    tce = (b.tc > NT) ? NT : b.tc;
    ie = 1 + tce + $countones(b.mask);
    push_model(tce, b.nx, b.ny);
    for (int c = 0; c <= b.done + 1; c++) begin
      @(negedge clk);
      start = (c == 0) || (b.hold && c <= b.done);
      tid_count = (TW+1)'(b.tc);
      ntid_x = TW'(b.nx);
      ntid_y = TW'(b.ny);
      stall = c >= 2 && c - 2 < 32 && b.mask[c-2];
      k = c - ie;
      cgra_done = !(k >= G && k < G + b.low);
      abort = b.abz && (c == 0 || c == b.done);
      #1;
      chk("ctl", 64'({start_ready, busy, cgra_clr, disp_valid, blk_done}),
          64'({c == 0 || c > b.done, c >= 1 && c <= b.done, c == 1,
               c >= 2 && c <= ie && !stall && tce > 0, c == b.done}));
      if (disp_valid) begin
        if (sbq.size() == 0) chk("extra_issue", 64'(disp_tid), 64'(1 << 20));
        else begin
          e = sbq.pop_front();
          chk("ids", 64'({disp_tid, tid_x, tid_y, tid_z}), 64'(e));
        end
      end
    end
    start = 0; stall = 0; abort = 0;
    chk("missing_issues", 64'(sbq.size()), 64'(0));
    sbq.delete();
  endtask

  initial begin
    int seen;
    tbl[0] = '{6, 2, 3, 32'h0, 0, 0, 0, 10};
    tbl[1] = '{4, 2, 2, 32'h6, 0, 0, 0, 10};
    tbl[2] = '{0, 1, 1, 32'h0, 0, 0, 0, 2};
    tbl[3] = '{5, 3, 2, 32'h0, 5, 0, 0, 14};
    tbl[4] = '{7, 0, 0, 32'h0, 0, 0, 0, 11};
    tbl[5] = '{600, 8, 8, 32'h0, 0, 0, 0, 516};
    tbl[6] = '{3, 4, 2, 32'h0, 0, 1, 1, 7};
    tbl[7] = '{9, 3, 0, 32'h15, 1, 0, 0, 2 + 9 + 3 + 3};
    #1;
    chk("reset_outs", 64'({start_ready, busy, cgra_clr, disp_valid, blk_done, disp_tid, tid_x, tid_y, tid_z}),
        64'({5'b10000, 36'h0}));
    repeat (2) @(negedge clk);
    rst_n = 1;
    foreach (tbl[i]) run_block(tbl[i]);

    // abort on the third issue of a 10-thread block
    @(negedge clk);
    start = 1; tid_count = 10; ntid_x = 4; ntid_y = 4; cgra_done = 1;
    @(negedge clk); start = 0; #1;
    chk("ab_clear", 64'(cgra_clr), 64'(1));
    @(negedge clk); #1;
    chk("ab_i0", 64'({disp_valid, disp_tid}), 64'({1'b1, 9'd0}));
    @(negedge clk); #1;
    chk("ab_i1", 64'({disp_valid, disp_tid}), 64'({1'b1, 9'd1}));
    @(negedge clk); abort = 1; #1;
    chk("ab_cycle", 64'({disp_valid, cgra_clr}), 64'(2'b01));
    @(negedge clk); abort = 0; #1;
    chk("ab_idle", 64'({start_ready, busy, blk_done, cgra_clr}), 64'(4'b1000));
    seen = 0;
    repeat (4) begin
      @(negedge clk); #1;
      seen += int'(blk_done);
    end
    chk("ab_no_done", 64'(seen), 64'(0));
    run_block('{3, 4, 4, 32'h0, 0, 0, 0, 7});

    // asynchronous reset in the middle of ISSUE
    @(negedge clk);
    start = 1; tid_count = 8; ntid_x = 4; ntid_y = 2;
    @(negedge clk); start = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_pre", 64'({disp_valid, disp_tid}), 64'({1'b1, 9'd2}));
    @(posedge clk); #2;
    rst_n = 0; #1;
    chk("rst_mid", 64'({start_ready, busy, cgra_clr, disp_valid, blk_done, disp_tid, tid_x, tid_y, tid_z}),
        64'({5'b10000, 36'h0}));
    seen = 0;
    repeat (2) begin
      @(negedge clk); #1;
      seen += int'(blk_done);
    end
    chk("rst_no_done", 64'(seen), 64'(0));
    rst_n = 1;
    run_block('{8, 4, 2, 32'h0, 0, 0, 0, 12});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
